aes128_inv_iter: RTL and testbench

AES128_INV_ITER -- requirements
Module: aes128_inv_iter

---
 rtl/aes128_inv_iter.sv | 250 +++++++++++++++++++++++++
 tb/tb_aes128_inv_iter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_inv_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aes128_inv_iter
// Description : Iterative AES-128 decryptor. The forward key schedule is run
//               for 10 cycles to reach round key 10. Then 10 inverse rounds
//               are run, one per cycle, while the round key is walked back
//               down with the reverse schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_inv_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_KEXP  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;

    localparam logic [3:0] c_KEXP_LAST = 4'd10;
    localparam logic [3:0] c_ROUND_TOP = 4'd9;

    // ------------------------------------------------------------------------
    // GF(2^8) helpers (polynomial x^8 + x^4 + x^3 + x + 1)
    // ------------------------------------------------------------------------
    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = f_xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0 naturally)
    function automatic logic [7:0] f_ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = f_gmul(sq, sq);
            acc = f_gmul(acc, sq);
        end
        return acc;
    endfunction

    // Forward S-box: inverse followed by the affine transform
    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = f_ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the inverse
    function automatic logic [7:0] f_inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return f_ginv(t);
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]   r_fsm;
    logic [1:0]   w_fsm_nxt;
    logic [127:0] r_data;
    logic [127:0] r_rk;
    logic [3:0]   r_cnt;     // rcon index in KEXP, round number in ROUND
    logic         r_done;
    logic [127:0] r_plain;

    // ------------------------------------------------------------------------
    // Key schedule step (forward in KEXP, reverse in ROUND)
    // ------------------------------------------------------------------------
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_pw1, w_pw2, w_pw3;
    logic [31:0]  w_ks_in, w_ks_rot, w_ks_sub;
    logic [7:0]   w_rcon;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [127:0] w_fwd_key;
    logic [127:0] w_rev_key;

    assign {w_w0, w_w1, w_w2, w_w3} = r_rk;

    // Previous-key words w1..w3 only need the XOR of neighbours
    assign w_pw3 = w_w3 ^ w_w2;
    assign w_pw2 = w_w2 ^ w_w1;
    assign w_pw1 = w_w1 ^ w_w0;

    // One SubWord unit is shared: forward uses old w3, reverse uses new w3
    assign w_ks_in  = (r_fsm == S_ROUND) ? w_pw3 : w_w3;
    assign w_ks_rot = {w_ks_in[23:0], w_ks_in[31:24]};
    assign w_rcon   = f_rcon((r_fsm == S_ROUND) ? (r_cnt + 4'd1) : r_cnt);

    genvar gk;
    generate
        for (gk = 0; gk < 4; gk++) begin : g_ks_sbox
            assign w_ks_sub[31-8*gk -: 8] = f_sbox(w_ks_rot[31-8*gk -: 8]);
        end
    endgenerate

    assign w_f0 = w_w0 ^ w_ks_sub ^ {w_rcon, 24'h000000};
    assign w_f1 = w_w1 ^ w_f0;
    assign w_f2 = w_w2 ^ w_f1;
    assign w_f3 = w_w3 ^ w_f2;
    assign w_fwd_key = {w_f0, w_f1, w_f2, w_f3};
    assign w_rev_key = {w_w0 ^ w_ks_sub ^ {w_rcon, 24'h000000}, w_pw1, w_pw2, w_pw3};

    // ------------------------------------------------------------------------
    // Inverse round datapath
    // ------------------------------------------------------------------------
    logic [127:0] w_isb;     // InvSubBytes(InvShiftRows(state))
    logic [127:0] w_ark;     // ... XOR rk(r)
    logic [127:0] w_imc;     // InvMixColumns of the above
    logic [127:0] w_round;

    genvar gb;
    generate
        for (gb = 0; gb < 16; gb++) begin : g_inv_shift_sub
            // Row r is rotated right by r: output (row, col) reads (row, col-row)
            localparam int ROW = gb % 4;
            localparam int COL = gb / 4;
            localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
            assign w_isb[127-8*gb -: 8] = f_inv_sbox(r_data[127-8*SRC -: 8]);
        end
    endgenerate

    assign w_ark = w_isb ^ w_rev_key;

    genvar gc;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_inv_mix
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = w_ark[127-32*gc -: 8];
            assign w_a1 = w_ark[119-32*gc -: 8];
            assign w_a2 = w_ark[111-32*gc -: 8];
            assign w_a3 = w_ark[103-32*gc -: 8];
            assign w_imc[127-32*gc -: 32] = {
                f_gmul(w_a0, 8'h0e) ^ f_gmul(w_a1, 8'h0b) ^ f_gmul(w_a2, 8'h0d) ^ f_gmul(w_a3, 8'h09),
                f_gmul(w_a0, 8'h09) ^ f_gmul(w_a1, 8'h0e) ^ f_gmul(w_a2, 8'h0b) ^ f_gmul(w_a3, 8'h0d),
                f_gmul(w_a0, 8'h0d) ^ f_gmul(w_a1, 8'h09) ^ f_gmul(w_a2, 8'h0e) ^ f_gmul(w_a3, 8'h0b),
                f_gmul(w_a0, 8'h0b) ^ f_gmul(w_a1, 8'h0d) ^ f_gmul(w_a2, 8'h09) ^ f_gmul(w_a3, 8'h0e)};
        end
    endgenerate

    // Last round (r = 0) skips InvMixColumns
    assign w_round = (r_cnt == 4'd0) ? w_ark : w_imc;

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    // Next-state decode
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (start)                 w_fsm_nxt = S_KEXP;
            S_KEXP:  if (r_cnt == c_KEXP_LAST)  w_fsm_nxt = S_ROUND;
            S_ROUND: if (r_cnt == 4'd0)         w_fsm_nxt = S_IDLE;
            default:                            w_fsm_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: capture, key expansion, inverse rounds, result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= 128'h0;
            r_rk    <= 128'h0;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
            r_plain <= 128'h0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (start) begin
                        r_data <= ciphertext;
                        r_rk   <= key;
                        r_cnt  <= 4'd1;
                    end
                end
                S_KEXP: begin
                    r_rk <= w_fwd_key;
                    if (r_cnt == c_KEXP_LAST) begin
                        // Initial AddRoundKey with the freshly derived round key 10
                        r_data <= r_data ^ w_fwd_key;
                        r_cnt  <= c_ROUND_TOP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_ROUND: begin
                    r_rk   <= w_rev_key;
                    r_data <= w_round;
                    if (r_cnt == 4'd0) begin
                        r_plain <= w_round;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_fsm != S_IDLE);
    assign done      = r_done;
    assign plaintext = r_plain;

endmodule
`default_nettype wire

// File: tb/tb_aes128_inv_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes128_inv_iter
// Description : Self-checking bench for aes128_inv_iter. A byte-level AES
//               model gives expected plaintexts; a transaction-level timing
//               model gives expected busy/done/plaintext every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_inv_iter;

    typedef logic [10:0][127:0] rks_t;

    localparam logic [127:0] c_K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int           c_LAT = 20;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    aes128_inv_iter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // Byte-level AES reference
    // ------------------------------------------------------------------------
    function automatic logic [7:0] gb(input logic [127:0] v, input int n);
        return v[127-8*n -: 8];
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built by walking the multiplicative group with generator 3
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv ? isb[gb(v, n)] : sb[gb(v, n)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) begin
            int r, c, sc;
            r  = n % 4;
            c  = n / 4;
            sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
            o[127-8*n -: 8] = gb(v, r + 4 * sc);
        end
        return o;
    endfunction

    // Circulant column mix; coef holds the first matrix row
    function automatic logic [127:0] mix(input logic [127:0] v, input logic [31:0] coef);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc;
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gm(coef[31-8*((j - r + 4) % 4) -: 8], gb(v, 4 * c + j));
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic rks_t expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rks_t        rk;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        rks_t         rk;
        logic [127:0] s;
        rk = expand(k);
        s  = p ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r < 10) s = mix(s, 32'h02030101);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] c);
        rks_t         rk;
        logic [127:0] s;
        rk = expand(k);
        s  = c ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r];
            if (r > 0) s = mix(s, 32'h0e0b0d09);
        end
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Transaction-level timing model: accept when idle, done 20 edges later
    // ------------------------------------------------------------------------
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic [127:0] m_plain = 128'h0;
    logic [127:0] m_exp   = 128'h0;
    int           m_cnt   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_plain = 128'h0;
            m_cnt   = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_plain = m_exp;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_cnt  = c_LAT;
                m_exp  = aes_dec(key, ciphertext);
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            n_cmp++;
            if (busy !== m_busy || done !== m_done || plaintext !== m_plain) begin
                n_bad++;
                $display("FAIL cycle t=%0t: busy=%b done=%b pt=%h, required busy=%b done=%b pt=%h",
                         $time, busy, done, plaintext, m_busy, m_done, m_plain);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Check helpers and stimulus
    // ------------------------------------------------------------------------
    task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present an operation and count edges after acceptance until done.
    // hold=0 scrambles inputs after acceptance; pulse_at re-raises start.
    task automatic launch(input logic [127:0] k, input logic [127:0] ct,
                          input bit hold, input int pulse_at, output int lat);
        key        = k;
        ciphertext = ct;
        start      = 1'b1;
        lat        = -1;
        for (int i = 0; i <= 40; i++) begin
            @(posedge clk);
            #2;
            if (!hold) begin
                start      = (i == pulse_at);
                key        = rnd128();
                ciphertext = rnd128();
            end
            if (i >= 1 && done) begin
                lat = i;
                break;
            end
        end
    endtask

    // Global time limit
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic [127:0] k, p;

        rst        = 1'b1;
        start      = 1'b0;
        key        = 128'h0;
        ciphertext = 128'h0;
        build_tables();
        chk_en     = 1'b1;

        // Hand-computed pins on the reference model itself
        chk128("model_sbox00", {120'h0, sb[8'h00]}, 128'h63);
        chk128("model_sbox53", {120'h0, sb[8'h53]}, 128'hed);
        chk128("model_isbox63", {120'h0, isb[8'h63]}, 128'h00);
        chk128("model_enc_c1", aes_enc(c_K1, c_P1), c_C1);
        chk128("model_enc_b", aes_enc(c_K2, c_P2), c_C2);
        chk128("model_dec_b", aes_dec(c_K2, c_C2), c_P2);

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk128("rst_busy", {127'h0, busy}, 128'h0);
        chk128("rst_done", {127'h0, done}, 128'h0);
        chk128("rst_plaintext", plaintext, 128'h0);

        // C.1 on the first edge after reset release
        @(negedge clk);
        rst = 1'b0;
        launch(c_K1, c_C1, 1'b0, -1, lat);
        chki("c1_latency", lat, c_LAT);
        chk128("c1_plaintext", plaintext, c_P1);

        // Appendix B
        launch(c_K2, c_C2, 1'b0, -1, lat);
        chki("b_latency", lat, c_LAT);
        chk128("b_plaintext", plaintext, c_P2);

        // start while busy is ignored
        launch(c_K1, c_C1, 1'b0, 5, lat);
        chki("ignore_latency", lat, c_LAT);
        chk128("ignore_plaintext", plaintext, c_P1);
        repeat (25) @(posedge clk);
        #2;
        chk128("ignore_no_second_op", {127'h0, busy}, 128'h0);

        // Back-to-back with start held high, vectors alternating on done
        for (int op = 0; op < 4; op++) begin
            launch(op % 2 ? c_K2 : c_K1, op % 2 ? c_C2 : c_C1, 1'b1, -1, lat);
            chki("b2b_latency", lat, c_LAT);
            chk128("b2b_plaintext", plaintext, op % 2 ? c_P2 : c_P1);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(posedge clk);

        // Reset in the middle of an operation
        @(negedge clk);
        key        = c_K1;
        ciphertext = c_C1;
        start      = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk128("midrst_busy", {127'h0, busy}, 128'h0);
        chk128("midrst_done", {127'h0, done}, 128'h0);
        chk128("midrst_plaintext", plaintext, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        launch(c_K1, c_C1, 1'b0, -1, lat);
        chki("restart_latency", lat, c_LAT);
        chk128("restart_plaintext", plaintext, c_P1);

        // Random pairs encrypted by the model and fed back in
        for (int n = 0; n < 1000; n++) begin
            if (n_bad > 50) break;
            k = rnd128();
            p = rnd128();
            launch(k, aes_enc(k, p), 1'b0,
                   ($urandom_range(3) == 0) ? int'($urandom_range(19, 1)) : -1, lat);
            chki("rand_latency", lat, c_LAT);
            chk128("rand_plaintext", plaintext, p);
        end

        repeat (3) @(posedge clk);
        #3;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
